// File: rtl/pip_read_scheduler.sv
// pip_read_scheduler: shares one burst-read memory port between the
// main-video FIFO (ch1) and the thermal PIP FIFO (ch2).
module pip_read_scheduler #(
    parameter int          BURST      = 64,
    parameter int          FIFO_TH    = 256,
    parameter logic [23:0] BASE1      = 24'h000000,
    parameter logic [23:0] BASE2      = 24'h100000,
    parameter int          FRAME1     = 307200,
    parameter int          FRAME2     = 12288,
    parameter int          STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_start,
    input  logic [9:0]  fifo1_usedw,
    input  logic [9:0]  fifo2_usedw,
    output logic        mem_rd_req,
    output logic [23:0] mem_rd_addr,
    output logic [7:0]  mem_rd_len,
    input  logic        mem_rd_ack,
    input  logic        mem_rd_done,
    output logic [1:0]  grant_ch,
    output logic        busy,
    output logic [1:0]  frame_fetched
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_ARB,
        S_REQ,
        S_XFER
    } state_t;

    localparam logic [23:0] L_BURST = 24'(BURST);
    localparam logic [23:0] L_FRM1  = 24'(FRAME1);
    localparam logic [23:0] L_FRM2  = 24'(FRAME2);
    localparam logic [10:0] L_TH    = 11'(FIFO_TH);
    localparam logic [2:0]  L_SMAX  = 3'(STARVE_MAX);

    state_t      r_state;
    state_t      w_next;
    logic [23:0] r_addr1;
    logic [23:0] r_addr2;
    logic [23:0] r_rem1;
    logic [23:0] r_rem2;
    logic [23:0] r_addr_o;
    logic [7:0]  r_len;
    logic [1:0]  r_grant;
    logic [1:0]  r_fetched;
    logic [2:0]  r_starve;
    logic        r_pend;
    logic        r_sel;

    logic        w_need1;
    logic        w_need2;
    logic        w_any;
    logic        w_sel2;
    logic [23:0] w_rem_sel;
    logic [23:0] w_addr_sel;
    logic [23:0] w_xlen;
    logic [7:0]  w_len;

    assign w_need1 = ({1'b0, fifo1_usedw} < L_TH)
                     && (r_rem1 != '0) && !r_pend;
    assign w_need2 = ({1'b0, fifo2_usedw} < L_TH)
                     && (r_rem2 != '0) && !r_pend;
    assign w_any   = w_need1 || w_need2;
    assign w_sel2  = w_need2 && (!w_need1 || (r_starve == L_SMAX));

    assign w_rem_sel  = w_sel2 ? r_rem2 : r_rem1;
    assign w_addr_sel = w_sel2 ? r_addr2 : r_addr1;
    assign w_len      = (w_rem_sel < L_BURST) ? w_rem_sel[7:0]
                                              : L_BURST[7:0];
    assign w_xlen     = {16'd0, r_len};

    assign mem_rd_req    = (r_state == S_REQ);
    assign busy          = (r_state != S_IDLE);
    assign mem_rd_addr   = r_addr_o;
    assign mem_rd_len    = r_len;
    assign grant_ch      = r_grant;
    assign frame_fetched = r_fetched;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state; an ARB cycle that finds nothing to fetch falls back.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_any) w_next = S_ARB;
            S_ARB:   w_next = w_any ? S_REQ : S_IDLE;
            S_REQ:   if (mem_rd_ack) w_next = S_XFER;
            S_XFER:  if (mem_rd_done) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Channel pointers, burst registers, starvation and frame tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr1   <= BASE1;
            r_addr2   <= BASE2;
            r_rem1    <= '0;
            r_rem2    <= '0;
            r_addr_o  <= '0;
            r_len     <= '0;
            r_grant   <= 2'b00;
            r_fetched <= 2'b11;
            r_starve  <= '0;
            r_pend    <= 1'b0;
            r_sel     <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (r_pend) begin
                        r_addr1   <= BASE1;
                        r_addr2   <= BASE2;
                        r_rem1    <= L_FRM1;
                        r_rem2    <= L_FRM2;
                        r_fetched <= 2'b00;
                        r_starve  <= '0;
                        r_pend    <= 1'b0;
                    end
                end
                S_ARB: begin
                    if (w_any) begin
                        r_addr_o <= w_addr_sel;
                        r_len    <= w_len;
                        r_sel    <= w_sel2;
                        r_grant  <= w_sel2 ? 2'b10 : 2'b01;
                        if (w_sel2) begin
                            r_starve <= '0;
                        end else if (w_need2 && r_starve < L_SMAX) begin
                            r_starve <= r_starve + 3'd1;
                        end
                    end
                end
                S_XFER: begin
                    if (mem_rd_done) begin
                        r_grant <= 2'b00;
                        if (r_sel) begin
                            r_addr2 <= r_addr2 + w_xlen;
                            r_rem2  <= r_rem2 - w_xlen;
                            if (r_rem2 == w_xlen) r_fetched[1] <= 1'b1;
                        end else begin
                            r_addr1 <= r_addr1 + w_xlen;
                            r_rem1  <= r_rem1 - w_xlen;
                            if (r_rem1 == w_xlen) r_fetched[0] <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
            // A vsync arriving on the reload cycle re-arms another reload.
            if (frame_start) r_pend <= 1'b1;
        end
    end
endmodule

// File: tb/tb_pip_read_scheduler.sv
// tb_pip_read_scheduler: memory-port responder plus a frame-level
// model of the two channels; checks the scheduler every cycle.
module tb_pip_read_scheduler;
    localparam int          F1   = 640;
    localparam int          F2   = 100;
    localparam int          BRST = 64;
    localparam int          TH   = 256;
    localparam int          SMAX = 4;
    localparam logic [23:0] B1   = 24'h000000;
    localparam logic [23:0] B2   = 24'h100000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_start = 1'b0;
    logic [9:0]  fifo1_usedw = '0;
    logic [9:0]  fifo2_usedw = '0;
    logic        mem_rd_req;
    logic [23:0] mem_rd_addr;
    logic [7:0]  mem_rd_len;
    logic        mem_rd_ack = 1'b0;
    logic        mem_rd_done = 1'b0;
    logic [1:0]  grant_ch;
    logic        busy;
    logic [1:0]  frame_fetched;

    pip_read_scheduler #(
        .BURST(BRST), .FIFO_TH(TH), .BASE1(B1), .BASE2(B2),
        .FRAME1(F1), .FRAME2(F2), .STARVE_MAX(SMAX)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
        .fifo1_usedw(fifo1_usedw), .fifo2_usedw(fifo2_usedw),
        .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr),
        .mem_rd_len(mem_rd_len), .mem_rd_ack(mem_rd_ack),
        .mem_rd_done(mem_rd_done), .grant_ch(grant_ch),
        .busy(busy), .frame_fetched(frame_fetched)
    );

    always #15 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // channel model: index 0 = main video, 1 = PIP
    int m_addr [2];
    int m_rem  [2];
    int m_fet;
    int m_starve;
    bit m_pend;

    // burst in flight
    int c_ch, c_addr, c_len;

    typedef enum {P_WAIT, P_ACK, P_DONE, P_POST} ph_t;
    ph_t ph;
    int acnt, dcnt, idle_cnt, reqcyc;
    int ack_dly, done_dly;
    bit rnd_en, fs_req, ff_req;
    int f1_next, f2_next;

    int log_addr [$];
    int log_len  [$];
    int log_ch   [$];
    int log_rc   [$];

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic int pick();
        int v [6] = '{0, 100, 255, 256, 300, 1023};
        return v[$urandom_range(0, 5)];
    endfunction

    function automatic bit need(input int ch);
        int lvl = (ch == 0) ? int'(fifo1_usedw) : int'(fifo2_usedw);
        return (lvl < TH) && (m_rem[ch] != 0);
    endfunction

    function automatic int gexp();
        return (c_ch == 1) ? 2 : 1;
    endfunction

    task automatic model_reset();
        m_addr[0] = int'(B1);
        m_addr[1] = int'(B2);
        m_rem[0] = 0;
        m_rem[1] = 0;
        m_fet = 3;
        m_starve = 0;
        m_pend = 1'b0;
        ph = P_WAIT;
        idle_cnt = 0;
        fs_req = 1'b0;
        ff_req = 1'b0;
        log_addr.delete();
        log_len.delete();
        log_ch.delete();
        log_rc.delete();
    endtask

    task automatic model_reload();
        m_addr[0] = int'(B1);
        m_addr[1] = int'(B2);
        m_rem[0] = F1;
        m_rem[1] = F2;
        m_fet = 0;
        m_starve = 0;
        m_pend = 1'b0;
    endtask

    task automatic new_req();
        bit n1, n2, s2;
        n1 = need(0);
        n2 = need(1);
        if (m_pend) chk("req_in_pend", int'(mem_rd_req), 0);
        if (!n1 && !n2) chk("spurious_req", int'(mem_rd_req), 0);
        s2 = n2 && (!n1 || m_starve == SMAX);
        c_ch = s2 ? 1 : 0;
        c_addr = m_addr[c_ch];
        c_len = (m_rem[c_ch] < BRST) ? m_rem[c_ch] : BRST;
        if (s2) m_starve = 0;
        else if (n2 && m_starve < SMAX) m_starve++;
        log_addr.push_back(c_addr);
        log_len.push_back(c_len);
        log_ch.push_back(c_ch + 1);
        acnt = (ack_dly < 0) ? int'($urandom_range(0, 3)) : ack_dly;
        reqcyc = 0;
        ph = P_ACK;
    endtask

    task automatic model_done();
        m_addr[c_ch] += c_len;
        m_rem[c_ch] -= c_len;
        if (m_rem[c_ch] == 0) m_fet |= (1 << c_ch);
        log_rc.push_back(reqcyc);
    endtask

    task automatic apply_ff();
        fifo1_usedw = 10'(f1_next);
        fifo2_usedw = 10'(f2_next);
        ff_req = 1'b0;
    endtask

    task automatic step();
        bit fs_now;
        fs_now = 1'b0;
        @(negedge clk);
        mem_rd_ack = 1'b0;
        mem_rd_done = 1'b0;
        frame_start = 1'b0;
        if (rnd_en) begin
            if (!fs_req && $urandom_range(0, 59) == 0) fs_req = 1'b1;
            if (!ff_req && $urandom_range(0, 7) == 0) begin
                ff_req = 1'b1;
                f1_next = pick();
                f2_next = pick();
            end
        end
        if (!m_pend) chk("fetched", int'(frame_fetched), m_fet);
        if (ph == P_WAIT && mem_rd_req) begin
            idle_cnt = 0;
            new_req();
        end
        if (ph == P_ACK) begin
            chk("req_high", int'(mem_rd_req), 1);
            chk("addr", int'(mem_rd_addr), c_addr);
            chk("len", int'(mem_rd_len), c_len);
            chk("grant_req", int'(grant_ch), gexp());
            chk("busy_req", int'(busy), 1);
            reqcyc++;
            if (acnt == 0) begin
                mem_rd_ack = 1'b1;
                dcnt = (done_dly < 0) ? int'($urandom_range(0, 3))
                                      : done_dly;
                ph = P_DONE;
            end else begin
                acnt--;
            end
        end else if (ph == P_DONE) begin
            chk("req_low", int'(mem_rd_req), 0);
            chk("grant_xfer", int'(grant_ch), gexp());
            chk("busy_xfer", int'(busy), 1);
            if (fs_req) begin
                frame_start = 1'b1;
                fs_req = 1'b0;
                m_pend = 1'b1;
            end
            if (ff_req) apply_ff();
            if (dcnt == 0) begin
                mem_rd_done = 1'b1;
                model_done();
                ph = P_POST;
            end else begin
                dcnt--;
            end
        end else if (ph == P_POST) begin
            chk("req_post", int'(mem_rd_req), 0);
            chk("grant_post", int'(grant_ch), 0);
            chk("busy_post", int'(busy), 0);
            ph = P_WAIT;
            idle_cnt = 1;
        end else begin
            if (busy) idle_cnt = 0;
            else idle_cnt++;
            if (!m_pend && idle_cnt >= 3 && (need(0) || need(1))) begin
                chk("stuck_idle", int'(busy), 1);
                idle_cnt = 0;
            end
            if (!m_pend && idle_cnt >= 2) begin
                if (fs_req) begin
                    frame_start = 1'b1;
                    fs_req = 1'b0;
                    m_pend = 1'b1;
                    fs_now = 1'b1;
                    idle_cnt = 0;
                end else if (ff_req) begin
                    apply_ff();
                    idle_cnt = 0;
                end
            end
        end
        if (ph == P_WAIT && m_pend && !busy && !fs_now) begin
            model_reload();
            idle_cnt = 0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        mem_rd_ack = 1'b0;
        mem_rd_done = 1'b0;
        frame_start = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_req", int'(mem_rd_req), 0);
        chk("rst_addr", int'(mem_rd_addr), 0);
        chk("rst_len", int'(mem_rd_len), 0);
        chk("rst_grant", int'(grant_ch), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_fetched", int'(frame_fetched), 3);
        rst_n = 1'b1;
    endtask

    task automatic run_until(input int n, input int budget);
        int k;
        k = 0;
        while (log_addr.size() < n && k < budget) begin
            step();
            k++;
        end
        chk("req_timeout", log_addr.size(), n);
    endtask

    task automatic run_done(input int n, input int budget);
        int k;
        k = 0;
        while (log_rc.size() < n && k < budget) begin
            step();
            k++;
        end
        chk("done_timeout", log_rc.size(), n);
    endtask

    initial begin
        int exp_ch [10] = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2};
        ack_dly = 1;
        done_dly = 1;
        rnd_en = 1'b0;
        f1_next = 0;
        f2_next = 0;

        // V1: ch1 only, first two bursts
        fifo1_usedw = 10'd0;
        fifo2_usedw = 10'd300;
        do_reset();
        fs_req = 1'b1;
        run_until(2, 200);
        if (log_addr.size() >= 2) begin
            chk("v1_addr0", log_addr[0], 'h000000);
            chk("v1_len0", log_len[0], 64);
            chk("v1_ch0", log_ch[0], 1);
            chk("v1_addr1", log_addr[1], 'h000040);
        end

        // V2: starvation pattern
        fifo1_usedw = 10'd0;
        fifo2_usedw = 10'd0;
        do_reset();
        fs_req = 1'b1;
        run_until(10, 400);
        if (log_addr.size() >= 10) begin
            for (int i = 0; i < 10; i++) chk("v2_ch", log_ch[i], exp_ch[i]);
            chk("v2_addr4", log_addr[4], 'h100000);
            chk("v2_addr5", log_addr[5], 'h000100);
            chk("v2_addr9", log_addr[9], 'h100040);
        end

        // V3: short PIP frame, tail burst, then silence
        fifo1_usedw = 10'd300;
        fifo2_usedw = 10'd0;
        do_reset();
        fs_req = 1'b1;
        run_until(2, 200);
        repeat (40) step();
        chk("v3_count", log_addr.size(), 2);
        if (log_addr.size() >= 2) begin
            chk("v3_len0", log_len[0], 64);
            chk("v3_len1", log_len[1], 36);
            chk("v3_addr1", log_addr[1], 'h100040);
            chk("v3_ch1", log_ch[1], 2);
        end
        chk("v3_fetched", int'(frame_fetched), 2);

        // V4: vsync during a burst restarts ch1 at its base
        fifo1_usedw = 10'd0;
        fifo2_usedw = 10'd300;
        do_reset();
        fs_req = 1'b1;
        run_until(3, 300);
        fs_req = 1'b1;
        run_until(5, 300);
        if (log_addr.size() >= 5) begin
            chk("v4_addr2", log_addr[2], 'h000080);
            chk("v4_addr3", log_addr[3], 'h000000);
            chk("v4_ch3", log_ch[3], 1);
            chk("v4_addr4", log_addr[4], 'h000040);
        end

        // V5: ack withheld for 10 cycles
        ack_dly = 10;
        do_reset();
        fs_req = 1'b1;
        run_done(1, 300);
        if (log_rc.size() >= 1) chk("v5_req_cycles", log_rc[0], 11);
        ack_dly = 1;

        // V6: reset while requesting, stray done afterwards
        fifo1_usedw = 10'd0;
        fifo2_usedw = 10'd0;
        do_reset();
        fs_req = 1'b1;
        run_until(1, 200);
        #2 rst_n = 1'b0;
        #1;
        chk("v6_req", int'(mem_rd_req), 0);
        chk("v6_busy", int'(busy), 0);
        chk("v6_grant", int'(grant_ch), 0);
        chk("v6_fetched", int'(frame_fetched), 3);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mem_rd_done = 1'b1;
        mem_rd_ack = 1'b1;
        repeat (30) step();
        chk("v6_no_req", log_addr.size(), 0);
        chk("v6_idle", int'(busy), 0);

        // Randomized traffic
        ack_dly = -1;
        done_dly = -1;
        rnd_en = 1'b1;
        fifo1_usedw = 10'(pick());
        fifo2_usedw = 10'(pick());
        do_reset();
        fs_req = 1'b1;
        repeat (8000) step();
        rnd_en = 1'b0;
        chk("rand_activity", int'(log_addr.size() > 50), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
